// File: rtl/fifo_key_pulser.sv
// Push-button front end for the FIFO controller: synchronizes and debounces the
// write/read keys and issues single-cycle write/read strobes or drop pulses.

module fifo_key_pulser_deb #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pressed,
  output logic fire_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_REL
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // fire_c is high only on the transition DEB_PRESS -> PRESSED
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fire_c   = 1'b0;
    case (state)
      IDLE: begin
        if (pressed) begin
          state_nx = DEB_PRESS;
          cnt_nx   = '0;
        end
      end
      DEB_PRESS: begin
        if (!pressed) begin
          state_nx = IDLE;
        end else if (cnt == CNT_MAX) begin
          state_nx = PRESSED;
          fire_c   = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_nx = DEB_REL;
          cnt_nx   = '0;
        end
      end
      DEB_REL: begin
        if (pressed) begin
          state_nx = PRESSED;
        end else if (cnt == CNT_MAX) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

module fifo_key_pulser #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_wr_n,
  input  logic             key_rd_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             full,
  input  logic             empty,
  output logic             write,
  output logic             read,
  output logic [WIDTH-1:0] wr_data,
  output logic             wr_drop,
  output logic             rd_drop
);

  logic             wr_s1;
  logic             wr_s2;
  logic             rd_s1;
  logic             rd_s2;
  logic [WIDTH-1:0] sw_s1;
  logic [WIDTH-1:0] sw_s2;
  logic             wr_pressed_c;
  logic             rd_pressed_c;
  logic             wr_fire_c;
  logic             rd_fire_c;

  // Two-flop synchronizers; keys reset to the released level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_s1 <= 1'b1;
      wr_s2 <= 1'b1;
      rd_s1 <= 1'b1;
      rd_s2 <= 1'b1;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      wr_s1 <= key_wr_n;
      wr_s2 <= wr_s1;
      rd_s1 <= key_rd_n;
      rd_s2 <= rd_s1;
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  assign wr_pressed_c = ~wr_s2;
  assign rd_pressed_c = ~rd_s2;

  fifo_key_pulser_deb #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_wr (
    .clk    (clk),
    .reset  (reset),
    .pressed(wr_pressed_c),
    .fire_c (wr_fire_c)
  );

  fifo_key_pulser_deb #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_rd (
    .clk    (clk),
    .reset  (reset),
    .pressed(rd_pressed_c),
    .fire_c (rd_fire_c)
  );

  // A fire becomes a strobe or a drop depending on FIFO status at the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write   <= 1'b0;
      read    <= 1'b0;
      wr_drop <= 1'b0;
      rd_drop <= 1'b0;
      wr_data <= '0;
    end else begin
      write   <= wr_fire_c & ~full;
      wr_drop <= wr_fire_c & full;
      read    <= rd_fire_c & ~empty;
      rd_drop <= rd_fire_c & empty;
      if (wr_fire_c && !full) begin
        wr_data <= sw_s2;
      end
    end
  end

endmodule
